// File: rtl/st_adapter_pkg.sv
// Shared types and width/slice helpers for the Avalon-ST width adapters.
package st_adapter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } st_state_t;

  localparam int DEF_IN_W  = 512;
  localparam int DEF_OUT_W = 64;

  // Narrow beats carried by one wide beat.
  function automatic int ratio_of(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Bytes carried by one narrow slice.
  function automatic int bps_of(input int out_w);
    return out_w / 8;
  endfunction

  // Width of an empty field for a data bus; kept at least 1 so an 8-bit bus still has a legal port.
  function automatic int empty_width(input int data_w);
    int w;
    w = $clog2(data_w / 8);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a slice index for the given ratio.
  function automatic int index_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

  // Slices to emit for a wide beat; whole empty slices at the tail of an EOP beat are dropped.
  function automatic int slice_count(input logic eop, input int empty_bytes,
                                     input int ratio, input int bps);
    int n;
    if (!eop) return ratio;
    n = ratio - (empty_bytes / bps);
    return (n < 1) ? 1 : n;
  endfunction

  // Empty bytes left over inside the final slice.
  function automatic int empty_rem(input int empty_bytes, input int bps);
    return empty_bytes % bps;
  endfunction

  localparam int DEF_RATIO       = ratio_of(DEF_IN_W, DEF_OUT_W);
  localparam int DEF_BPS         = bps_of(DEF_OUT_W);
  localparam int DEF_IN_EMPTY_W  = empty_width(DEF_IN_W);
  localparam int DEF_OUT_EMPTY_W = empty_width(DEF_OUT_W);

endpackage

// File: rtl/st_downsizer.sv
// Wide-to-narrow Avalon-ST adapter: holds one wide beat and emits it as OUT_W slices.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no beat held, in_ready high
// ST_SEND | beat held, slices idx..last_idx still pending
module st_downsizer
  import st_adapter_pkg::*;
#(
  parameter int IN_W      = 512,
  parameter int OUT_W     = 64,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IN_EMPTY_W  = empty_width(IN_W),
  localparam int OUT_EMPTY_W = empty_width(OUT_W)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [IN_EMPTY_W-1:0]  in_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [OUT_EMPTY_W-1:0] out_empty
);

  localparam int RATIO = ratio_of(IN_W, OUT_W);
  localparam int BPS   = bps_of(OUT_W);
  localparam int IDX_W = index_width(RATIO);

  st_state_t state, state_nxt;

  logic [RATIO-1:0][OUT_W-1:0] buf_data;
  logic                        buf_sop;
  logic                        buf_eop;
  logic [OUT_EMPTY_W-1:0]      buf_rem;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            last_idx;
  logic [IDX_W-1:0]            sel_idx;
  logic [IDX_W-1:0]            in_last_idx;
  logic [OUT_EMPTY_W-1:0]      in_rem;
  logic                        is_last;
  logic                        take_out;
  logic                        accept;

  assign out_valid = (state == ST_SEND);
  assign is_last   = (idx == last_idx);
  assign take_out  = out_valid && out_ready;
  // Final-slice handshake frees the buffer in the same cycle, so a new beat loads with no bubble.
  assign in_ready  = (state == ST_IDLE) || (take_out && is_last);
  assign accept    = in_valid && in_ready;

  // Slice count and tail-empty split of the incoming beat, stored as a last index.
  always_comb begin
    in_last_idx = IDX_W'(slice_count(in_endofpacket, int'(in_empty), RATIO, BPS) - 1);
    in_rem      = OUT_EMPTY_W'(empty_rem(int'(in_empty), BPS));
  end

  // Map the emission index onto the physical slice position for the chosen order.
  always_comb begin
    sel_idx = idx;
    if (!LSB_FIRST) sel_idx = IDX_W'(RATIO - 1) - idx;
  end

  // Narrow outputs are decoded from held registers, so they stay stable under backpressure.
  always_comb begin
    out_data          = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    if (out_valid) begin
      out_data          = buf_data[sel_idx];
      out_startofpacket = buf_sop && (idx == '0);
      out_endofpacket   = buf_eop && is_last;
      if (out_endofpacket) out_empty = buf_rem;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: load on accept, drain to idle when the last slice leaves with nothing behind it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)            state_nxt = ST_SEND;
      ST_SEND: if (take_out && is_last) state_nxt = in_valid ? ST_SEND : ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Control side of the held beat and the slice index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_sop  <= 1'b0;
      buf_eop  <= 1'b0;
      buf_rem  <= '0;
      last_idx <= '0;
      idx      <= '0;
    end else if (accept) begin
      buf_sop  <= in_startofpacket;
      buf_eop  <= in_endofpacket;
      buf_rem  <= in_rem;
      last_idx <= in_last_idx;
      idx      <= '0;
    end else if (take_out) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

  // Wide data buffer; contents are only observed while in ST_SEND, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) buf_data <= in_data;
  end

endmodule

// File: tb/tb_st_downsizer.sv
// Directed bench for st_downsizer: one LSB-first and one MSB-first instance share the stimulus.
module tb_st_downsizer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready, m_in_ready;
  logic [511:0] in_data;
  logic         in_sop, in_eop;
  logic [5:0]   in_empty;
  logic         out_valid, m_out_valid;
  logic         out_ready;
  logic [63:0]  out_data, m_out_data;
  logic         out_sop, out_eop, m_out_sop, m_out_eop;
  logic [2:0]   out_empty, m_out_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  st_downsizer #(.IN_W(512), .OUT_W(64), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty)
  );

  st_downsizer #(.IN_W(512), .OUT_W(64), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_startofpacket(m_out_sop), .out_endofpacket(m_out_eop), .out_empty(m_out_empty)
  );

  // Wide beat whose slice k holds base + k.
  function automatic logic [511:0] mk_beat(input logic [63:0] base);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one slice on the LSB-first instance.
  task automatic chk_slice(input string tag, input logic [63:0] exp_data, input logic exp_sop,
                           input logic exp_eop, input logic [2:0] exp_empty, input logic exp_ready);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".data"},  out_data,       exp_data);
    chk({tag, ".sop"},   64'(out_sop),   64'(exp_sop));
    chk({tag, ".eop"},   64'(out_eop),   64'(exp_eop));
    chk({tag, ".empty"}, 64'(out_empty), 64'(exp_empty));
    chk({tag, ".ready"}, 64'(in_ready),  64'(exp_ready));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".data"},  out_data,       64'd0);
    chk({tag, ".sop"},   64'(out_sop),   64'd0);
    chk({tag, ".eop"},   64'(out_eop),   64'd0);
    chk({tag, ".empty"}, 64'(out_empty), 64'd0);
    chk({tag, ".ready"}, 64'(in_ready),  64'd1);
  endtask

  // Presents one beat in IDLE and lets it be accepted on the next edge.
  task automatic send_beat(input string tag, input logic [63:0] base, input logic sop,
                           input logic eop, input logic [5:0] empty);
    in_valid = 1'b1;
    in_data  = mk_beat(base);
    in_sop   = sop;
    in_eop   = eop;
    in_empty = empty;
    #1;
    chk({tag, ".accept_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_empty = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_empty  = '0;
    out_ready = 1'b1;

    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.data",  out_data,       64'd0);
    chk("rst.sop",   64'(out_sop),   64'd0);
    chk("rst.eop",   64'(out_eop),   64'd0);
    chk("rst.empty", 64'(out_empty), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    chk_idle("post_rst");

    // Single full SOP+EOP beat, slice k = k; MSB-first instance must give 7..0.
    send_beat("t1", 64'h0, 1'b1, 1'b1, 6'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_slice($sformatf("t1.k%0d", k), 64'(k), k == 0, k == 7, 3'd0, k == 7);
      chk($sformatf("t1.msb.k%0d", k), m_out_data, 64'(7 - k));
      chk($sformatf("t1.msb_valid.k%0d", k), 64'(m_out_valid), 64'd1);
      tick();
    end
    #1;
    chk_idle("t1.end");
    chk("t1.msb_end.valid", 64'(m_out_valid), 64'd0);

    // EOP beat with 21 empty bytes: 6 slices, 5 empty bytes on the last.
    tick();
    send_beat("t2", 64'h200, 1'b1, 1'b1, 6'd21);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk_slice($sformatf("t2.k%0d", k), 64'h200 + 64'(k), k == 0, k == 5,
                (k == 5) ? 3'd5 : 3'd0, k == 5);
      chk($sformatf("t2.msb.k%0d", k), m_out_data, 64'h200 + 64'(7 - k));
      chk($sformatf("t2.msb_eop.k%0d", k), 64'(m_out_eop), 64'(k == 5));
      tick();
    end
    #1;
    chk_idle("t2.end");

    // Three back-to-back beats with in_valid held high: 24 slices, no bubble.
    tick();
    in_valid = 1'b1;
    in_data  = mk_beat(64'h3000);
    in_sop   = 1'b1;
    in_eop   = 1'b0;
    in_empty = '0;
    #1;
    chk("t3.first_ready", 64'(in_ready), 64'd1);
    tick();
    for (int c = 0; c < 24; c++) begin
      int b;
      int k;
      b = c / 8;
      k = c % 8;
      if (b < 2) begin
        in_valid = 1'b1;
        in_data  = mk_beat(64'h3000 + 64'(b + 1) * 64'h100);
        in_sop   = 1'b0;
        in_eop   = (b + 1 == 2);
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
        in_eop   = 1'b0;
      end
      #1;
      chk_slice($sformatf("t3.c%0d", c), 64'h3000 + 64'(b) * 64'h100 + 64'(k),
                (b == 0) && (k == 0), (b == 2) && (k == 7), 3'd0, k == 7);
      tick();
    end
    #1;
    chk_idle("t3.end");

    // Backpressure for 3 cycles on slice 2.
    tick();
    send_beat("t4", 64'h400, 1'b1, 1'b1, 6'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_slice($sformatf("t4.k%0d", k), 64'h400 + 64'(k), k == 0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk_slice($sformatf("t4.stall%0d", s), 64'h402, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      #1;
      chk_slice($sformatf("t4.k%0d", k), 64'h400 + 64'(k), 1'b0, k == 7, 3'd0, k == 7);
      tick();
    end
    #1;
    chk_idle("t4.end");

    // Reset pulse at slice 4 drops the held beat.
    tick();
    send_beat("t5", 64'h500, 1'b1, 1'b1, 6'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_slice($sformatf("t5.k%0d", k), 64'h500 + 64'(k), k == 0, 1'b0, 3'd0, 1'b0);
      if (k < 4) tick();
    end
    reset_n = 1'b0;
    #1;
    chk("t5.rst.valid", 64'(out_valid), 64'd0);
    chk("t5.rst.data",  out_data,       64'd0);
    chk("t5.rst.msb_valid", 64'(m_out_valid), 64'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk_idle("t5.released");
    tick();
    #1;
    chk_idle("t5.idle2");
    send_beat("t5b", 64'h600, 1'b1, 1'b1, 6'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_slice($sformatf("t5b.k%0d", k), 64'h600 + 64'(k), k == 0, k == 7, 3'd0, k == 7);
      tick();
    end
    #1;
    chk_idle("t5b.end");

    // Maximum empty: 63 bytes leaves a single slice with 7 empty bytes.
    tick();
    send_beat("t6", 64'h700, 1'b1, 1'b1, 6'd63);
    #1;
    chk_slice("t6.k0", 64'h700, 1'b1, 1'b1, 3'd7, 1'b1);
    chk("t6.msb.k0", m_out_data, 64'h707);
    tick();
    #1;
    chk_idle("t6.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/st_downsizer.md
ST_DOWNSIZER -- requirements
Module: st_downsizer

Interface
REQ-001 SHALL have parameter IN_W, default 512, input data width in bits.
REQ-002 SHALL have parameter OUT_W, default 64, output data width in bits; IN_W SHALL be an integer multiple ≥2 of OUT_W, and OUT_W a multiple of 8.
REQ-003 SHALL have parameter LSB_FIRST, default 1, slice order: 1 = bits [OUT_W-1:0] first, 0 = MSB slice first.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, IN_W), in_startofpacket (input, 1), in_endofpacket (input, 1), in_empty (input, clog2(IN_W/8)): wide Avalon-ST sink; in_empty is the count of unused bytes on an EOP beat.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_W), out_startofpacket (output, 1), out_endofpacket (output, 1), out_empty (output, clog2(OUT_W/8)): narrow Avalon-ST source.

Function
REQ-008 SHALL define RATIO = IN_W/OUT_W and BPS = OUT_W/8 bytes per slice.
REQ-009 SHALL run two states: IDLE (no beat held) and SEND (beat held, slices pending).
REQ-010 SHALL accept an input beat on a cycle with in_valid && in_ready, registering data, SOP, EOP, empty, and entering SEND.
REQ-011 SHALL drive in_ready combinationally = (state==IDLE) || (out_valid && out_ready && last slice), giving zero-bubble back-to-back beats.
REQ-012 SHALL assert out_valid in SEND only, first slice on the cycle after acceptance (latency 1).
REQ-013 SHALL compute slice count N = RATIO for non-EOP beats and N = RATIO − floor(in_empty/BPS) for EOP beats, clamped to minimum 1.
REQ-014 SHALL advance slice index only on out_valid && out_ready; out_data, out_empty and SOP/EOP SHALL hold stable while out_valid && !out_ready.
REQ-015 SHALL present slice k from bits [k*OUT_W +: OUT_W] when LSB_FIRST=1, else from [(RATIO−1−k)*OUT_W +: OUT_W].
REQ-016 SHALL assert out_startofpacket only on slice 0 of a SOP beat and out_endofpacket only on slice N−1 of an EOP beat.
REQ-017 SHALL drive out_empty = in_empty mod BPS on the EOP slice, 0 otherwise.
REQ-018 SHALL, on final-slice handshake with no new input, return to IDLE; with simultaneous new input, reload buffer, reset index to 0, stay in SEND.
REQ-019 SHALL accept a beat carrying both SOP and EOP as a single-beat packet.
REQ-020 SHALL drive out_data to 0 when out_valid is low.
REQ-021 SHALL not check packet framing; SOP/EOP pass through as received.

Reset
REQ-022 SHALL, on reset_n low, asynchronously set state=IDLE, slice index=0, out_valid=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, out_data=0; in_ready SHALL read 1 from the first cycle after reset release.
REQ-023 SHALL discard any held beat when reset asserts mid-SEND; no residual slice is emitted after release.

Structure
REQ-024 SHALL place the slice-count/empty-split helper functions and width localparams (RATIO, BPS, empty widths) in shared package st_adapter_pkg.
REQ-025 SHALL be a single module with no sub-modules; data buffer is not reset (control path only).

Verification
REQ-026 SHALL test single full beat, IN_W=512/OUT_W=64, SOP+EOP, empty=0, out_ready=1 → 8 slices on cycles 1..8, SOP on slice 0, EOP on slice 7, out_empty=0.
REQ-027 SHALL test EOP beat with in_empty=21 → N=6 slices, EOP on slice 5, out_empty=5.
REQ-028 SHALL test continuous in_valid, 3-beat packet, out_ready=1 → 24 contiguous out_valid cycles, no bubble, in_ready high only on slice 7 cycles.
REQ-029 SHALL test out_ready deasserted for 3 cycles at slice 2 → out_data/flags held, no slice lost or duplicated, in_ready low throughout.
REQ-030 SHALL test LSB_FIRST=0 with in_data slice k = k → output sequence 7,6,…,0.
REQ-031 SHALL test reset_n pulsed low at slice 4 → out_valid=0 immediately, IDLE after release, next accepted beat starts at slice 0.
